// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU: accept, execute, respond.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties) instead of round-robin.
module alu_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [CTRL_W-1:0] req_control0,
   input  logic [CTRL_W-1:0] req_control1,
   input  logic [WIDTH-1:0]  req_a0,
   input  logic [WIDTH-1:0]  req_a1,
   input  logic [WIDTH-1:0]  req_b0,
   input  logic [WIDTH-1:0]  req_b1,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero,
   output logic              alu_reset,
   output logic [CTRL_W-1:0] alu_control,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t            state_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  result_q;
   logic              zero_q;
   logic              gnt_q;
   logic              winner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic              rr_q;
`endif

   // A lone requester always wins; ties are broken by the configured policy.
   always_comb begin
      winner_d = 1'b0;
      if (req_valid == 2'b10) begin
         winner_d = 1'b1;
      end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         winner_d = 1'b0;
`else
         winner_d = rr_q;
`endif
      end
   end

   always_comb begin
      req_ready = 2'b00;
      if (!reset && state_q == IDLE && req_valid != 2'b00) begin
         req_ready = winner_d ? 2'b10 : 2'b01;
      end
   end

   assign rsp_valid   = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_result  = result_q;
   assign rsp_zero    = zero_q;
   assign alu_reset   = reset;
   assign alu_control = ctrl_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;

   // The op registers keep driving the ALU in every state, so it never sees X.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         ctrl_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         gnt_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         rr_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid != 2'b00) begin
                  gnt_q   <= winner_d;
                  ctrl_q  <= winner_d ? req_control1 : req_control0;
                  a_q     <= winner_d ? req_a1 : req_a0;
                  b_q     <= winner_d ? req_b1 : req_b0;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               result_q <= alu_result;
               zero_q   <= alu_zero;
               state_q  <= RESP;
            end
            RESP: begin
               if (rsp_ready[gnt_q]) begin
                  state_q <= IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  rr_q    <= ~gnt_q;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// against a transaction-level model; honours ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_arbiter;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_OR  = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h6;
   localparam logic [3:0] OP_SLT = 4'h7;
   localparam logic [3:0] OP_NOR = 4'hC;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_control0;
   logic [3:0]  req_control1;
   logic [31:0] req_a0;
   logic [31:0] req_a1;
   logic [31:0] req_b0;
   logic [31:0] req_b1;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic        alu_reset;
   logic [3:0]  alu_control;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        alu_zero;

   int assertCount = 0;
   int failCount   = 0;

   alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_control0 (req_control0),
      .req_control1 (req_control1),
      .req_a0       (req_a0),
      .req_a1       (req_a1),
      .req_b0       (req_b0),
      .req_b1       (req_b1),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .alu_reset    (alu_reset),
      .alu_control  (alu_control),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero)
   );

   always #5 clock = ~clock;

   // Stand-in for the shared ALU; unknown codes yield 0.
   function automatic logic [31:0] aluFn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_NOR:  return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   assign alu_result = aluFn(alu_control, alu_a, alu_b);
   assign alu_zero   = (alu_result == 32'd0);

   function automatic logic pickWinner(input logic [1:0] v, input logic rr);
      if (v == 2'b10) return 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (v == 2'b11) return 1'b0;
`else
      if (v == 2'b11) return rr;
`endif
      return 1'b0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
      end
   endtask

   // Transaction model: one op in flight, response visible two cycles after its accept.
   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
   } op_t;

   op_t         lastOp;
   op_t         pendOp;
   logic        pendValid = 1'b0;
   logic        pendPort  = 1'b0;
   logic        rrM       = 1'b0;
   int          acceptCyc = 0;
   int          cyc       = 0;
   logic [31:0] lastResult;
   logic        lastZero;
   bit          modelReady = 1'b0;

   always @(negedge clock) begin
      logic [1:0] expReady;
      logic [1:0] expRspValid;
      logic       win;
      logic       wasPending;
      cyc++;
      checkOutput("alu_reset", 32'(alu_reset), 32'(reset));
      if (reset) begin
         checkOutput("req_ready_in_reset", 32'(req_ready), 32'd0);
         pendValid  = 1'b0;
         lastOp     = '0;
         lastResult = 32'd0;
         lastZero   = 1'b0;
         rrM        = 1'b0;
         modelReady = 1'b1;
      end else if (modelReady) begin
         if (pendValid && cyc == acceptCyc + 2) begin
            lastResult = aluFn(pendOp.ctrl, pendOp.a, pendOp.b);
            lastZero   = (lastResult == 32'd0);
         end
         win = pickWinner(req_valid, rrM);
         expReady    = (!pendValid && req_valid != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
         expRspValid = (pendValid && cyc >= acceptCyc + 2) ? (pendPort ? 2'b10 : 2'b01) : 2'b00;
         checkOutput("model_req_ready", 32'(req_ready), 32'(expReady));
         checkOutput("model_rsp_valid", 32'(rsp_valid), 32'(expRspValid));
         checkOutput("model_rsp_result", rsp_result, lastResult);
         checkOutput("model_rsp_zero", 32'(rsp_zero), 32'(lastZero));
         checkOutput("model_alu_control", 32'(alu_control), 32'(lastOp.ctrl));
         checkOutput("model_alu_a", alu_a, lastOp.a);
         checkOutput("model_alu_b", alu_b, lastOp.b);
         wasPending = pendValid;
         if (pendValid && cyc >= acceptCyc + 2 && rsp_ready[pendPort]) begin
            pendValid = 1'b0;
            rrM       = ~pendPort;
         end
         if (!wasPending && req_valid != 2'b00) begin
            pendValid = 1'b1;
            pendPort  = win;
            acceptCyc = cyc;
            pendOp    = win ? {req_control1, req_a1, req_b1} : {req_control0, req_a0, req_b0};
            lastOp    = pendOp;
         end
      end
   end

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] valid,
                                input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic [1:0] rr);
      req_valid    = valid;
      req_control0 = c0;
      req_a0       = a0;
      req_b0       = b0;
      req_control1 = c1;
      req_a1       = a1;
      req_b1       = b1;
      rsp_ready    = rr;
   endtask

   task automatic doReset(input int n);
      reset = 1'b1;
      repeat (n) nextCycle();
      reset = 1'b0;
   endtask

   logic [1:0]  hold;
   logic [3:0]  rc [2];
   logic [31:0] ra [2];
   logic [31:0] rb [2];
   logic [1:0]  expCont;

   initial begin
      reset = 1'b1;
      applyStimulus(2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b11);
      doReset(3);

      // Reset state with no requests pending.
      @(negedge clock);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_result", rsp_result, 32'd0);
      checkOutput("reset_rsp_zero", 32'(rsp_zero), 32'd0);
      checkOutput("reset_alu_a", alu_a, 32'd0);
      nextCycle();

      // Single ADD on port 0.
      applyStimulus(2'b01, OP_ADD, 32'd5, 32'd7, 4'h0, 32'd0, 32'd0, 2'b11);
      @(negedge clock);
      checkOutput("add_req_ready", 32'(req_ready), 32'h1);
      nextCycle();
      applyStimulus(2'b00, OP_ADD, 32'd5, 32'd7, 4'h0, 32'd0, 32'd0, 2'b11);
      @(negedge clock);
      checkOutput("add_rsp_valid_early", 32'(rsp_valid), 32'h0);
      nextCycle();
      @(negedge clock);
      checkOutput("add_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("add_rsp_result", rsp_result, 32'd12);
      checkOutput("add_rsp_zero", 32'(rsp_zero), 32'd0);
      nextCycle();

      // SUB producing zero on port 1.
      applyStimulus(2'b10, 4'h0, 32'd0, 32'd0, OP_SUB, 32'd9, 32'd9, 2'b11);
      @(negedge clock);
      checkOutput("sub_req_ready", 32'(req_ready), 32'h2);
      nextCycle();
      applyStimulus(2'b00, 4'h0, 32'd0, 32'd0, OP_SUB, 32'd9, 32'd9, 2'b11);
      nextCycle();
      @(negedge clock);
      checkOutput("sub_rsp_valid", 32'(rsp_valid), 32'h2);
      checkOutput("sub_rsp_result", rsp_result, 32'd0);
      checkOutput("sub_rsp_zero", 32'(rsp_zero), 32'd1);
      nextCycle();

      // Contention after reset: both ports valid for four operations.
      doReset(1);
      applyStimulus(2'b11, OP_ADD, 32'd1, 32'd1, OP_ADD, 32'd2, 32'd2, 2'b11);
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
`ifdef ALU_ARB_FIXED_PRIO_EN
         expCont = (k % 3 == 0) ? 2'b01 : 2'b00;
`else
         expCont = (k % 3 == 0) ? (((k / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
`endif
         checkOutput($sformatf("contention_cycle%0d", k), 32'(req_ready), 32'(expCont));
         nextCycle();
      end
      req_valid = 2'b00;
      repeat (3) nextCycle();

      // Response backpressure for five cycles, port 1 waiting meanwhile.
      doReset(1);
      applyStimulus(2'b01, OP_OR, 32'hF0, 32'h0F, OP_ADD, 32'd0, 32'd0, 2'b00);
      @(negedge clock);
      checkOutput("bp_req_ready", 32'(req_ready), 32'h1);
      nextCycle();
      req_valid = 2'b10;
      nextCycle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checkOutput($sformatf("bp_rsp_valid%0d", i), 32'(rsp_valid), 32'h1);
         checkOutput($sformatf("bp_rsp_result%0d", i), rsp_result, 32'hFF);
         checkOutput($sformatf("bp_req_ready%0d", i), 32'(req_ready), 32'h0);
         nextCycle();
      end
      rsp_ready = 2'b01;
      @(negedge clock);
      checkOutput("bp_release_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("bp_no_bypass", 32'(req_ready), 32'h0);
      nextCycle();
      rsp_ready = 2'b11;
      @(negedge clock);
      checkOutput("bp_next_accept", 32'(req_ready), 32'h2);
      nextCycle();
      req_valid = 2'b00;
      repeat (3) nextCycle();

      // Reset during EXEC drops the op; the held request is taken right after.
      applyStimulus(2'b01, OP_ADD, 32'd3, 32'd4, 4'h0, 32'd0, 32'd0, 2'b11);
      @(negedge clock);
      checkOutput("rexec_req_ready", 32'(req_ready), 32'h1);
      nextCycle();
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rexec_ready_forced", 32'(req_ready), 32'h0);
      nextCycle();
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rexec_reaccept", 32'(req_ready), 32'h1);
      checkOutput("rexec_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("rexec_rsp_result", rsp_result, 32'd0);
      nextCycle();
      req_valid = 2'b00;
      repeat (3) nextCycle();

      // Unknown opcode goes straight through and the ALU returns zero.
      applyStimulus(2'b01, 4'hF, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 2'b11);
      @(negedge clock);
      checkOutput("unk_req_ready", 32'(req_ready), 32'h1);
      nextCycle();
      req_valid = 2'b00;
      nextCycle();
      @(negedge clock);
      checkOutput("unk_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("unk_rsp_result", rsp_result, 32'd0);
      checkOutput("unk_rsp_zero", 32'(rsp_zero), 32'd1);
      nextCycle();

      // Random traffic; requesters hold operands until accepted.
      hold = 2'b00;
      for (int i = 0; i < 500; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!hold[p] && ($urandom % 3 == 0)) begin
               hold[p] = 1'b1;
               case ($urandom % 7)
                  0: rc[p] = OP_AND;
                  1: rc[p] = OP_OR;
                  2: rc[p] = OP_ADD;
                  3: rc[p] = OP_SUB;
                  4: rc[p] = OP_SLT;
                  5: rc[p] = OP_NOR;
                  default: rc[p] = 4'($urandom);
               endcase
               ra[p] = $urandom;
               rb[p] = ($urandom % 4 == 0) ? ra[p] : 32'($urandom);
            end
         end
         applyStimulus(hold, rc[0], ra[0], rb[0], rc[1], ra[1], rb[1],
                       ($urandom % 4 != 0) ? 2'b11 : 2'($urandom));
         reset = ($urandom % 80 == 0);
         @(negedge clock);
         for (int p = 0; p < 2; p++) begin
            if (req_ready[p]) hold[p] = 1'b0;
         end
         nextCycle();
      end

      reset     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      repeat (5) nextCycle();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
